hazard_detection_unit: RTL and testbench

//  ID-stage hazard controller that drives the control-bubble mux select (ctrl_sel) together with PC and IF/ID write/flush.

---
 rtl/cpu_hazard_pkg.sv | 12 +
 rtl/hazard_sat_counter.sv | 19 +
 rtl/hazard_detection_unit.sv | 126 ++++++++++++
 tb/tb_hazard_detection_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package cpu_hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_STALL,
        HZ_FLUSH
    } hz_state_t;

    localparam int REG_X0 = 0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: load-use stalls, taken-branch flushes and
// saturating performance counters for both.
//
//  state    | meaning
//  HZ_RUN   | normal issue; hazard/branch start an episode this cycle
//  HZ_STALL | remaining cycles of a multi-cycle load-use bubble
//  HZ_FLUSH | remaining cycles of a multi-cycle branch flush
module hazard_detection_unit
    import cpu_hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int LOAD_STALL   = 1,
    parameter int BRANCH_FLUSH = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_MemRead,
    input  logic              branch_taken,
    output logic              ctrl_sel,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_cycles
);

    localparam int MAX_LEN = (LOAD_STALL > BRANCH_FLUSH) ? LOAD_STALL : BRANCH_FLUSH;
    localparam int REM_W   = $clog2(MAX_LEN) + 1;

    localparam logic [REM_W-1:0] STALL_RELOAD = REM_W'(LOAD_STALL - 1);
    localparam logic [REM_W-1:0] FLUSH_RELOAD = REM_W'(BRANCH_FLUSH - 1);
    localparam logic [REM_W-1:0] REM_LAST     = REM_W'(1);

    hz_state_t        state, stateNext;
    logic [REM_W-1:0] rem, remNext;
    logic             hz;
    logic             stallCyc, flushCyc;

    assign hz = ex_MemRead && (ex_rd != REG_AW'(REG_X0)) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HZ_RUN;
            rem   <= '0;
        end else begin
            state <= stateNext;
            rem   <= remNext;
        end
    end

    // A taken branch always wins: it abandons any stall and restarts a flush.
    always_comb begin
        stateNext = state;
        remNext   = rem;
        stallCyc  = 1'b0;
        flushCyc  = 1'b0;
        if (branch_taken) begin
            flushCyc  = 1'b1;
            remNext   = FLUSH_RELOAD;
            stateNext = (BRANCH_FLUSH > 1) ? HZ_FLUSH : HZ_RUN;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (hz) begin
                        stallCyc  = 1'b1;
                        remNext   = STALL_RELOAD;
                        stateNext = (LOAD_STALL > 1) ? HZ_STALL : HZ_RUN;
                    end
                end
                HZ_STALL: begin
                    stallCyc = 1'b1;
                    remNext  = rem - 1'b1;
                    if (rem == REM_LAST) stateNext = HZ_RUN;
                end
                HZ_FLUSH: begin
                    flushCyc = 1'b1;
                    remNext  = rem - 1'b1;
                    if (rem == REM_LAST) stateNext = HZ_RUN;
                end
                default: begin
                    stateNext = HZ_RUN;
                    remNext   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ctrl_sel   = 1'b0;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        if (!reset) begin
            if (flushCyc) begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
            end else if (!stallCyc) begin
                ctrl_sel   = 1'b1;
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stallCyc),
        .count (stall_cycles)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flushCyc),
        .count (flush_cycles)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: three configurations share one stimulus
// stream and are checked against an episode-level reference model.
module tb_hazard_detection_unit;

    localparam logic [3:0] PASS_O  = 4'b1110;
    localparam logic [3:0] STALL_O = 4'b0000;
    localparam logic [3:0] FLUSH_O = 4'b0111;
    localparam logic [3:0] RESET_O = 4'b0000;

    // instance configs: 0 = LS1/BF1/16b, 1 = LS3/BF1/16b, 2 = LS2/BF3/4b
    int LS[3]   = '{1, 3, 2};
    int BF[3]   = '{1, 1, 3};
    int CMAX[3] = '{65535, 65535, 15};

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       uses2, memRead, branch;

    logic [3:0]  obsOut[3];
    logic [15:0] obsStall[3], obsFlush[3];
    logic [3:0]  stallC, flushC;

    // model state: mode 0 idle, 1 stalling, 2 flushing; left = cycles still owed
    int mMode[3], mLeft[3], mStall[3], mFlush[3];
    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.REG_AW(5), .LOAD_STALL(1), .BRANCH_FLUSH(1), .CNT_W(16)) dutA (
        .clk(clk), .reset(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
        .ex_rd(rd), .ex_MemRead(memRead), .branch_taken(branch),
        .ctrl_sel(obsOut[0][3]), .pc_write(obsOut[0][2]), .ifid_write(obsOut[0][1]),
        .ifid_flush(obsOut[0][0]), .stall_cycles(obsStall[0]), .flush_cycles(obsFlush[0]));

    hazard_detection_unit #(.REG_AW(5), .LOAD_STALL(3), .BRANCH_FLUSH(1), .CNT_W(16)) dutB (
        .clk(clk), .reset(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
        .ex_rd(rd), .ex_MemRead(memRead), .branch_taken(branch),
        .ctrl_sel(obsOut[1][3]), .pc_write(obsOut[1][2]), .ifid_write(obsOut[1][1]),
        .ifid_flush(obsOut[1][0]), .stall_cycles(obsStall[1]), .flush_cycles(obsFlush[1]));

    hazard_detection_unit #(.REG_AW(5), .LOAD_STALL(2), .BRANCH_FLUSH(3), .CNT_W(4)) dutC (
        .clk(clk), .reset(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
        .ex_rd(rd), .ex_MemRead(memRead), .branch_taken(branch),
        .ctrl_sel(obsOut[2][3]), .pc_write(obsOut[2][2]), .ifid_write(obsOut[2][1]),
        .ifid_flush(obsOut[2][0]), .stall_cycles(stallC), .flush_cycles(flushC));

    assign obsStall[2] = {12'd0, stallC};
    assign obsFlush[2] = {12'd0, flushC};

    function automatic bit hzNow();
        return memRead && (rd != 5'd0) && ((rd == rs1) || (uses2 && (rd == rs2)));
    endfunction

    function automatic logic [3:0] expOut(int i);
        if (rst) return RESET_O;
        if (branch || mMode[i] == 2) return FLUSH_O;
        if (mMode[i] == 1 || hzNow()) return STALL_O;
        return PASS_O;
    endfunction

    function automatic logic [15:0] expStall(int i);
        return rst ? 16'd0 : 16'(mStall[i]);
    endfunction

    function automatic logic [15:0] expFlush(int i);
        return rst ? 16'd0 : 16'(mFlush[i]);
    endfunction

    // Advance the model by one clock using the inputs of the cycle just ending.
    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            logic [3:0] o;
            o = expOut(i);
            if (rst) begin
                mMode[i] = 0; mLeft[i] = 0; mStall[i] = 0; mFlush[i] = 0;
                continue;
            end
            if (o == FLUSH_O && mFlush[i] < CMAX[i]) mFlush[i]++;
            if (o == STALL_O && mStall[i] < CMAX[i]) mStall[i]++;
            if (branch) begin
                mLeft[i] = BF[i] - 1;
                mMode[i] = (mLeft[i] > 0) ? 2 : 0;
            end else if (mMode[i] != 0) begin
                mLeft[i]--;
                if (mLeft[i] == 0) mMode[i] = 0;
            end else if (hzNow()) begin
                mLeft[i] = LS[i] - 1;
                mMode[i] = (mLeft[i] > 0) ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memRead = 0; branch = 0; uses2 = 0; rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic drain(int n);
        idle();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1; idle();
        @(negedge clk);
        checks++; if (obsOut[0] !== RESET_O) $display("FAIL reset_out got %b want %b", obsOut[0], RESET_O); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (obsStall[i] !== 16'd0 || obsFlush[i] !== 16'd0)
                $display("FAIL reset_cnt[%0d] got %0d/%0d want 0/0", i, obsStall[i], obsFlush[i]); else passes++;
        end
        tick();
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (obsOut[i] !== PASS_O) $display("FAIL release_out[%0d] got %b want %b", i, obsOut[i], PASS_O); else passes++;
        end
        tick();
    endtask

    task automatic test_load_use();
        memRead = 1; rd = 5; rs1 = 5;
        @(negedge clk);
        checks++; if (obsOut[0] !== STALL_O) $display("FAIL loaduse_stall got %b want %b", obsOut[0], STALL_O); else passes++;
        tick();
        idle();
        @(negedge clk);
        checks++; if (obsOut[0] !== PASS_O) $display("FAIL loaduse_after got %b want %b", obsOut[0], PASS_O); else passes++;
        checks++; if (obsStall[0] !== 16'd1) $display("FAIL loaduse_cnt got %0d want 1", obsStall[0]); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (obsOut[i] !== expOut(i)) $display("FAIL loaduse_model[%0d] got %b want %b", i, obsOut[i], expOut(i)); else passes++;
        end
        tick();
        drain(4);
    endtask

    task automatic test_x0_and_rs2();
        memRead = 1; rd = 0; rs1 = 0;
        @(negedge clk);
        checks++; if (obsOut[0] !== PASS_O) $display("FAIL x0_nostall got %b want %b", obsOut[0], PASS_O); else passes++;
        tick();
        rd = 7; rs1 = 3; rs2 = 7; uses2 = 0;
        @(negedge clk);
        checks++; if (obsOut[0] !== PASS_O) $display("FAIL rs2_unused got %b want %b", obsOut[0], PASS_O); else passes++;
        tick();
        uses2 = 1;
        @(negedge clk);
        checks++; if (obsOut[0] !== STALL_O) $display("FAIL rs2_used got %b want %b", obsOut[0], STALL_O); else passes++;
        tick();
        rs1 = 7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (obsOut[i] !== expOut(i)) $display("FAIL both_model[%0d] got %b want %b", i, obsOut[i], expOut(i)); else passes++;
            tick();
            idle();
        end
        drain(4);
    endtask

    task automatic test_branch_priority();
        int stallBefore, flushBefore;
        stallBefore = mStall[0]; flushBefore = mFlush[0];
        memRead = 1; rd = 9; rs1 = 9; branch = 1;
        @(negedge clk);
        checks++; if (obsOut[0] !== FLUSH_O) $display("FAIL branch_prio got %b want %b", obsOut[0], FLUSH_O); else passes++;
        tick();
        idle();
        @(negedge clk);
        checks++; if (obsFlush[0] !== 16'(flushBefore + 1)) $display("FAIL branch_fcnt got %0d want %0d", obsFlush[0], flushBefore + 1); else passes++;
        checks++; if (obsStall[0] !== 16'(stallBefore)) $display("FAIL branch_scnt got %0d want %0d", obsStall[0], stallBefore); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (obsOut[i] !== expOut(i)) $display("FAIL branch_model[%0d] got %b want %b", i, obsOut[i], expOut(i)); else passes++;
        end
        tick();
        drain(4);
    endtask

    task automatic test_long_stall();
        memRead = 1; rd = 4; rs1 = 4;
        @(negedge clk);
        checks++; if (obsOut[1] !== STALL_O) $display("FAIL long_c1 got %b want %b", obsOut[1], STALL_O); else passes++;
        tick();
        idle(); branch = 1;
        @(negedge clk);
        checks++; if (obsOut[1] !== FLUSH_O) $display("FAIL long_c2_branch got %b want %b", obsOut[1], FLUSH_O); else passes++;
        tick();
        branch = 0;
        @(negedge clk);
        checks++; if (obsOut[1] !== PASS_O) $display("FAIL long_c3 got %b want %b", obsOut[1], PASS_O); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (obsStall[i] !== expStall(i) || obsFlush[i] !== expFlush(i))
                $display("FAIL long_cnt[%0d] got %0d/%0d want %0d/%0d", i, obsStall[i], obsFlush[i], expStall(i), expFlush(i)); else passes++;
        end
        tick();
        drain(4);
    endtask

    task automatic test_saturation();
        for (int e = 0; e < 20; e++) begin
            memRead = 1; rd = 5'(1 + e % 31); rs1 = 5'(1 + e % 31);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++; if (obsOut[i] !== expOut(i) || obsStall[i] !== expStall(i))
                    $display("FAIL sat_ep%0d[%0d] got %b/%0d want %b/%0d", e, i, obsOut[i], obsStall[i], expOut(i), expStall(i)); else passes++;
            end
            tick();
            drain(3);
        end
        @(negedge clk);
        checks++; if (obsStall[2] !== 16'd15) $display("FAIL sat_hold got %0d want 15", obsStall[2]); else passes++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        memRead = 1; rd = 6; rs1 = 6;
        @(negedge clk);
        tick();
        idle(); rst = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (obsOut[i] !== RESET_O || obsStall[i] !== 16'd0)
                $display("FAIL midrst[%0d] got %b/%0d want %b/0", i, obsOut[i], obsStall[i], RESET_O); else passes++;
        end
        tick();
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (obsOut[i] !== PASS_O) $display("FAIL midrst_release[%0d] got %b want %b", i, obsOut[i], PASS_O); else passes++;
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            memRead = $urandom_range(0, 1);
            branch  = ($urandom_range(0, 9) == 0);
            uses2   = $urandom_range(0, 1);
            rd      = 5'($urandom_range(0, 3));
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++; if (obsOut[i] !== expOut(i) || obsStall[i] !== expStall(i) || obsFlush[i] !== expFlush(i))
                    $display("FAIL rand_c%0d[%0d] got %b/%0d/%0d want %b/%0d/%0d", c, i,
                             obsOut[i], obsStall[i], obsFlush[i], expOut(i), expStall(i), expFlush(i));
                else passes++;
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mMode[i] = 0; mLeft[i] = 0; mStall[i] = 0; mFlush[i] = 0;
        end
        test_reset();
        test_load_use();
        test_x0_and_rs2();
        test_branch_priority();
        test_long_stall();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
